// File: rtl/exit_status_monitor.sv
// exit_status_monitor
//   End-of-test monitor. Each of NUM_CH channels posts one exit code via a
//   valid/ready write port; the block folds them into a pass/fail/timeout
//   verdict, bounded by a cycle watchdog.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable_i        run enable; low returns to IDLE and clears all status
//   timeout_i       watchdog limit in cycles (0 = disabled)
//   wr_valid_i      exit-code write request
//   wr_ch_i         reporting channel
//   wr_code_i       exit code
//   wr_ready_o      writes accepted (high only in RUN)
//   ch_done_o       per-channel reported flags
//   done_o          verdict valid
//   pass_o, fail_o  verdict
//   timeout_o       watchdog expired
//   dup_err_o       sticky repeat / out-of-range write
//   exit_code_o     first non-pass code, else PASS_CODE
//   fail_ch_o       channel that produced exit_code_o
//   cycles_o        cycles spent in RUN
module exit_status_monitor #(
    parameter int                 NUM_CH    = 3,
    parameter int                 CODE_W    = 8,
    parameter logic [CODE_W-1:0]  PASS_CODE = '0,
    parameter int                 CNT_W     = 32,
    localparam int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  timeout_i,
    input  logic              wr_valid_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [CODE_W-1:0] wr_code_i,
    output logic              wr_ready_o,
    output logic [NUM_CH-1:0] ch_done_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic              dup_err_o,
    output logic [CODE_W-1:0] exit_code_o,
    output logic [CH_W-1:0]   fail_ch_o,
    output logic [CNT_W-1:0]  cycles_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] ch_done_q, ch_done_d, hit;
    logic              dup_q, fail_lat_q, timeout_q;
    logic [CODE_W-1:0] exit_code_q;
    logic [CH_W-1:0]   fail_ch_q;
    logic [CNT_W-1:0]  cycles_q;
    logic              acc, new_wr, dup_wr, expire;

    assign acc = wr_valid_i && (state_q == S_RUN);

    // One-hot channel decode; an out-of-range channel hits nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign hit[i] = acc && (wr_ch_i == CH_W'(i));
    end

    // Anything accepted that does not set a fresh flag is an error write.
    assign new_wr    = |(hit & ~ch_done_q);
    assign dup_wr    = acc && !new_wr;
    assign ch_done_d = ch_done_q | hit;

    // Completion is checked including this cycle's write, so a completing
    // write in the expiry cycle suppresses the timeout.
    assign expire = (timeout_i != '0) && (cycles_q == timeout_i - CNT_W'(1)) && !(&ch_done_d);

    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            state_q     <= S_IDLE;
            ch_done_q   <= '0;
            dup_q       <= 1'b0;
            fail_lat_q  <= 1'b0;
            timeout_q   <= 1'b0;
            exit_code_q <= PASS_CODE;
            fail_ch_q   <= '0;
            cycles_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_RUN;
                    cycles_q <= '0;
                end
                S_RUN: begin
                    ch_done_q <= ch_done_d;
                    if (dup_wr) dup_q <= 1'b1;
                    if (new_wr && (wr_code_i != PASS_CODE) && !fail_lat_q) begin
                        fail_lat_q  <= 1'b1;
                        exit_code_q <= wr_code_i;
                        fail_ch_q   <= wr_ch_i;
                    end
                    if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
                    // Registered set completes first, then the state moves.
                    if (&ch_done_q) begin
                        state_q <= S_DONE;
                    end else if (expire) begin
                        state_q   <= S_DONE;
                        timeout_q <= 1'b1;
                    end
                end
                S_DONE: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_ready_o  = (state_q == S_RUN);
    assign ch_done_o   = ch_done_q;
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && !timeout_q && !dup_q && !fail_lat_q;
    assign fail_o      = done_o && !pass_o;
    assign timeout_o   = timeout_q;
    assign dup_err_o   = dup_q;
    assign exit_code_o = exit_code_q;
    assign fail_ch_o   = fail_ch_q;
    assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_exit_status_monitor.sv
// Bench for exit_status_monitor: directed scenarios, a per-cycle compare
// against a behavioural model, and literal spot checks.
module tb_exit_status_monitor;

    logic        clk, rst, enable, wr_valid;
    logic [31:0] timeout;
    logic [1:0]  wr_ch;
    logic [7:0]  wr_code;
    logic        wr_ready, done, pass, fail, tmo, dup;
    logic [2:0]  ch_done;
    logic [7:0]  exit_code;
    logic [1:0]  fail_ch;
    logic [31:0] cycles;

    int pass_cnt = 0;
    int total    = 0;
    bit cmp_on   = 0;

    exit_status_monitor #(.NUM_CH(3), .CODE_W(8), .PASS_CODE(8'h00), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .timeout_i(timeout),
        .wr_valid_i(wr_valid), .wr_ch_i(wr_ch), .wr_code_i(wr_code),
        .wr_ready_o(wr_ready), .ch_done_o(ch_done), .done_o(done), .pass_o(pass),
        .fail_o(fail), .timeout_o(tmo), .dup_err_o(dup), .exit_code_o(exit_code),
        .fail_ch_o(fail_ch), .cycles_o(cycles)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Behavioural model: a run is a set of reported channels, a run-cycle
    // count and a finished flag; verdict fields follow from those.
    bit      m_run, m_fin, m_tmo, m_dup, m_fail;
    bit [2:0] m_rep;
    int      m_code, m_fch, before_n, after_n;
    longint  m_cyc;

    always @(posedge clk) begin
        if (rst || !enable) begin
            m_run = 0; m_fin = 0; m_tmo = 0; m_dup = 0; m_fail = 0;
            m_rep = 0; m_code = 0; m_fch = 0; m_cyc = 0;
        end else if (!m_run && !m_fin) begin
            m_run = 1; m_cyc = 0;
        end else if (m_run) begin
            before_n = $countones(m_rep);
            if (wr_valid) begin
                if (wr_ch >= 3) m_dup = 1;
                else if (m_rep[wr_ch]) m_dup = 1;
                else begin
                    m_rep[wr_ch] = 1;
                    if (wr_code != 0 && !m_fail) begin
                        m_fail = 1; m_code = wr_code; m_fch = wr_ch;
                    end
                end
            end
            after_n = $countones(m_rep);
            if (before_n == 3) begin
                m_run = 0; m_fin = 1;
            end else if (timeout != 0 && m_cyc == longint'(timeout) - 1 && after_n < 3) begin
                m_run = 0; m_fin = 1; m_tmo = 1;
            end
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        end
    end

    bit e_pass;
    always @(negedge clk) begin
        if (cmp_on) begin
            e_pass = m_fin && !m_tmo && !m_dup && !m_fail;
            chk("m_ready",   wr_ready,  m_run);
            chk("m_done",    done,      m_fin);
            chk("m_pass",    pass,      e_pass);
            chk("m_fail",    fail,      m_fin && !e_pass);
            chk("m_timeout", tmo,       m_tmo);
            chk("m_dup",     dup,       m_dup);
            chk("m_chdone",  ch_done,   m_rep);
            chk("m_code",    exit_code, m_fail ? m_code : 0);
            chk("m_failch",  fail_ch,   m_fail ? m_fch : 0);
            chk("m_cycles",  cycles,    m_cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] code);
        wr_valid = 1; wr_ch = ch; wr_code = code;
        tick();
        wr_valid = 0; wr_ch = 0; wr_code = 0;
    endtask

    task automatic start(input logic [31:0] t);
        timeout = t; enable = 1;
        tick();
    endtask

    task automatic stop();
        enable = 0;
        tick();
    endtask

    initial begin
        rst = 1; enable = 0; timeout = 0; wr_valid = 0; wr_ch = 0; wr_code = 0;
        tick(); cmp_on = 1; tick();
        rst = 0;
        chk("rst_done", done, 0);
        chk("rst_ready", wr_ready, 0);
        chk("rst_code", exit_code, 0);
        chk("rst_cycles", cycles, 0);

        // 1: all pass, out of order
        start(0);
        chk("t1_ready", wr_ready, 1);
        wr(2, 0); wr(0, 0); wr(1, 0);
        chk("t1_chdone", ch_done, 3'b111);
        chk("t1_not_yet", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_code", exit_code, 0);
        chk("t1_cycles", cycles, 4);
        stop();
        chk("t1_clr", done, 0);

        // 2: first failing code is latched
        start(0);
        wr(0, 0); wr(1, 8'h2A); wr(2, 8'h11);
        tick();
        chk("t2_fail", fail, 1);
        chk("t2_code", exit_code, 8'h2A);
        chk("t2_ch", fail_ch, 1);
        stop();

        // 3: watchdog
        start(100);
        wr(0, 0);
        for (int k = 0; k < 200 && !done; k++) tick();
        chk("t3_done", done, 1);
        chk("t3_tmo", tmo, 1);
        chk("t3_chdone", ch_done, 3'b001);
        chk("t3_cycles", cycles, 100);
        repeat (5) tick();
        chk("t3_hold", cycles, 100);
        stop();

        // 4: duplicate write discarded
        start(0);
        wr(1, 0); wr(1, 8'h05); wr(0, 0); wr(2, 0);
        tick();
        chk("t4_dup", dup, 1);
        chk("t4_fail", fail, 1);
        chk("t4_code", exit_code, 0);
        stop();

        // 4b: out-of-range channel
        start(0);
        wr(3, 8'h07); wr(0, 0); wr(1, 0); wr(2, 0);
        tick();
        chk("t4b_dup", dup, 1);
        chk("t4b_chdone", ch_done, 3'b111);
        chk("t4b_code", exit_code, 0);
        stop();

        // 5: completing write in the expiry cycle
        start(10);
        wr(0, 0); wr(1, 0);
        repeat (7) tick();
        wr(2, 0);
        tick();
        chk("t5_pass", pass, 1);
        chk("t5_tmo", tmo, 0);
        stop();
        chk("t5_clr_done", done, 0);
        chk("t5_clr_chdone", ch_done, 0);
        chk("t5_clr_cycles", cycles, 0);
        chk("t5_clr_ready", wr_ready, 0);

        // 6: reset mid-run, then a clean run
        start(0);
        wr(0, 0); wr(1, 0);
        rst = 1; tick(); rst = 0;
        chk("t6_rst_chdone", ch_done, 0);
        chk("t6_rst_ready", wr_ready, 0);
        tick();
        wr(0, 0); wr(1, 0); wr(2, 0);
        tick();
        chk("t6_pass", pass, 1);
        stop();
        wr(0, 8'h33); wr(1, 8'h44);
        chk("t6_idle_ready", wr_ready, 0);
        chk("t6_idle_chdone", ch_done, 0);
        chk("t6_idle_code", exit_code, 0);
        chk("t6_idle_done", done, 0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
